// File: rtl/snake_renderer.sv
// Snake game pixel renderer. It takes one snapshot of the game state per frame,
// finds the grid cell under the beam with running counters, and produces a
// registered colour two pixel strobes after each hCount/vCount.
module snake_renderer #(
  parameter int GRID_COLS  = 16,
  parameter int GRID_ROWS  = 16,
  parameter int LOC_W      = 8,
  parameter int CELL       = 30,
  parameter int MAX_LEN    = 16,
  parameter int H_ORIGIN   = 144,
  parameter int V_ORIGIN   = 35,
  parameter int BLINK_LOG2 = 4
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              Pix_En,
  input  logic                              Bright,
  input  logic [9:0]                        hCount,
  input  logic [9:0]                        vCount,
  input  logic                              Frame_Start,
  input  logic                              Qi,
  input  logic                              Qw,
  input  logic                              Ql,
  input  logic                              Qc,
  input  logic [$clog2(MAX_LEN+1)-1:0]      Length,
  input  logic [MAX_LEN*LOC_W-1:0]          Locations_Flat,
  input  logic [LOC_W-1:0]                  Food,
  output logic [11:0]                       rgb,
  output logic [11:0]                       background,
  output logic [BLINK_LOG2-1:0]             Frame_Count
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int XW    = $clog2(CELL + 1);
  localparam int CW    = $clog2(GRID_COLS + 1);
  localparam int RW    = $clog2(GRID_ROWS + 1);

  localparam logic [11:0] C_HEAD = 12'hF80;
  localparam logic [11:0] C_BODY = 12'hFF0;
  localparam logic [11:0] C_FOOD = 12'hFFF;
  localparam logic [11:0] C_LOSE = 12'hF00;
  localparam logic [11:0] C_WIN  = 12'h0F0;

  // Frame snapshot
  logic [LEN_W-1:0]      snap_len_q;
  logic [LOC_W-1:0]      snap_loc_q [MAX_LEN];
  logic [LOC_W-1:0]      snap_food_q;
  logic                  food_valid_q;
  logic [BLINK_LOG2-1:0] frame_cnt_q;
  logic [LEN_W-1:0]      len_clamped;

  // Beam position trackers (position of the last strobed pixel)
  logic [XW-1:0] xsub_q, xsub_d, ysub_q, ysub_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Pipeline
  logic [LOC_W-1:0] idx_q, idx_d;
  logic             in_grid_q, in_grid_d;
  logic             bright_q;
  logic [11:0]      rgb_q, pix_d;
  logic [11:0]      bg_q;
  logic             blink, head_hit, body_hit, food_hit;

  assign len_clamped = (Length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : Length;

  // Latch game state once per frame so the picture never tears
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      snap_len_q   <= '0;
      snap_food_q  <= '0;
      food_valid_q <= 1'b0;
      frame_cnt_q  <= '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) snap_loc_q[i] <= '0;
    end else if (Frame_Start) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
      for (int unsigned i = 0; i < MAX_LEN; i++)
        snap_loc_q[i] <= Locations_Flat[(MAX_LEN-1-i)*LOC_W +: LOC_W];
      if (Qc) snap_food_q <= Food;
      if (Qi) begin
        snap_len_q   <= '0;
        food_valid_q <= 1'b0;
      end else begin
        snap_len_q <= len_clamped;
        if (Qc) food_valid_q <= 1'b1;
      end
    end
  end

  // Cell position of the current pixel, derived from the previous strobe's position
  always_comb begin
    xsub_d = xsub_q;
    col_d  = col_q;
    ysub_d = ysub_q;
    row_d  = row_q;
    if (hCount == 10'(H_ORIGIN)) begin
      xsub_d = '0;
      col_d  = '0;
      if (vCount == 10'(V_ORIGIN)) begin
        ysub_d = '0;
        row_d  = '0;
      end else if (ysub_q == XW'(CELL - 1)) begin
        ysub_d = '0;
        if (row_q < RW'(GRID_ROWS)) row_d = row_q + 1'b1;
      end else begin
        ysub_d = ysub_q + 1'b1;
      end
    end else if (xsub_q == XW'(CELL - 1)) begin
      xsub_d = '0;
      if (col_q < CW'(GRID_COLS)) col_d = col_q + 1'b1;
    end else begin
      xsub_d = xsub_q + 1'b1;
    end
  end

  // Stage 1 inputs: cell index and visibility of the current pixel
  always_comb begin
    in_grid_d = (col_d < CW'(GRID_COLS)) && (row_d < RW'(GRID_ROWS)) &&
                (hCount >= 10'(H_ORIGIN)) && (vCount >= 10'(V_ORIGIN));
    idx_d     = LOC_W'(row_d * GRID_COLS + col_d);
  end

  // Stage 2 colour selection; head beats body beats food beats background
  always_comb begin
    blink    = Ql & frame_cnt_q[BLINK_LOG2-1];
    head_hit = in_grid_q && (snap_len_q != '0) && (idx_q == snap_loc_q[0]);
    body_hit = 1'b0;
    for (int unsigned i = 1; i < MAX_LEN; i++)
      if ((i < 32'(snap_len_q)) && (idx_q == snap_loc_q[i])) body_hit = 1'b1;
    body_hit = body_hit & in_grid_q;
    food_hit = in_grid_q && food_valid_q && (idx_q == snap_food_q);
    if (!bright_q)              pix_d = '0;
    else if (head_hit && !blink) pix_d = C_HEAD;
    else if (body_hit && !blink) pix_d = C_BODY;
    else if (food_hit)           pix_d = C_FOOD;
    else                         pix_d = bg_q;
  end

  // Trackers and both pipeline stages advance only on pixel strobes
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      xsub_q    <= '0;
      col_q     <= '0;
      ysub_q    <= '0;
      row_q     <= '0;
      idx_q     <= '0;
      in_grid_q <= 1'b0;
      bright_q  <= 1'b0;
      rgb_q     <= '0;
    end else if (Pix_En) begin
      xsub_q    <= xsub_d;
      col_q     <= col_d;
      ysub_q    <= ysub_d;
      row_q     <= row_d;
      idx_q     <= idx_d;
      in_grid_q <= in_grid_d;
      bright_q  <= Bright;
      rgb_q     <= pix_d;
    end
  end

  // Background colour follows game state every clock; lose outranks win
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)   bg_q <= '0;
    else if (Qi) bg_q <= '0;
    else if (Ql) bg_q <= C_LOSE;
    else if (Qw) bg_q <= C_WIN;
    else         bg_q <= '0;
  end

  assign rgb         = rgb_q;
  assign background  = bg_q;
  assign Frame_Count = frame_cnt_q;

endmodule

// File: tb/tb_snake_renderer.sv
// Self-checking bench for snake_renderer: background vector table plus a
// pixel scoreboard fed by a division-based reference model of the raster.
module tb_snake_renderer;
  localparam int GC = 16, GR = 16, LW = 8, CELL = 30, ML = 16;
  localparam int HO = 144, VO = 35, BL = 4;
  localparam int LENW = $clog2(ML + 1);

  logic            Clk = 1'b0;
  logic            Reset, Pix_En, Bright, Frame_Start, Qi, Qw, Ql, Qc;
  logic [9:0]      hCount, vCount;
  logic [LENW-1:0] Length;
  logic [ML*LW-1:0] Locations_Flat;
  logic [LW-1:0]   Food;
  logic [11:0]     rgb, background;
  logic [BL-1:0]   Frame_Count;

  always #5 Clk = ~Clk;

  snake_renderer #(
    .GRID_COLS(GC), .GRID_ROWS(GR), .LOC_W(LW), .CELL(CELL), .MAX_LEN(ML),
    .H_ORIGIN(HO), .V_ORIGIN(VO), .BLINK_LOG2(BL)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Pix_En(Pix_En), .Bright(Bright),
    .hCount(hCount), .vCount(vCount), .Frame_Start(Frame_Start),
    .Qi(Qi), .Qw(Qw), .Ql(Ql), .Qc(Qc), .Length(Length),
    .Locations_Flat(Locations_Flat), .Food(Food),
    .rgb(rgb), .background(background), .Frame_Count(Frame_Count)
  );

  typedef struct { bit chk; logic [11:0] exp; int h; int v; } sb_t;
  typedef struct { bit qi; bit qw; bit ql; bit qc; logic [11:0] bg; } bg_vec_t;

  sb_t sbq[$];
  int tests = 0, fails = 0;
  int p_len, p_loc[ML];
  int m_len, m_loc[ML], m_food, m_fc;
  bit m_fv;
  logic [11:0] last_exp;
  int fs_h = -1, fs_v = -1;
  bit gaps = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_snake(input int n, input int base);
    p_len  = n;
    Length = LENW'(n);
    for (int i = 0; i < ML; i++) begin
      p_loc[i] = base + i;
      Locations_Flat[(ML-1-i)*LW +: LW] = LW'(base + i);
    end
  endtask

  function automatic logic [11:0] mbg();
    if (Qi) return 12'h000;
    if (Ql) return 12'hF00;
    if (Qw) return 12'h0F0;
    return 12'h000;
  endfunction

  task automatic model_snap();
    m_fc = (m_fc + 1) % (1 << BL);
    for (int i = 0; i < ML; i++) m_loc[i] = p_loc[i];
    if (Qc) m_food = int'(Food);
    if (Qi) begin
      m_len = 0;
      m_fv  = 0;
    end else begin
      m_len = (p_len > ML) ? ML : p_len;
      if (Qc) m_fv = 1;
    end
  endtask

  function automatic logic [11:0] mpix(input int h, input int v, input bit br);
    int c, r, idx;
    bit blink;
    if (!br) return 12'h000;
    if (h < HO || v < VO) return mbg();
    c = (h - HO) / CELL;
    r = (v - VO) / CELL;
    if (c >= GC || r >= GR) return mbg();
    idx   = r * GC + c;
    blink = Ql && (m_fc >= (1 << (BL - 1)));
    if (!blink) begin
      if (m_len >= 1 && idx == m_loc[0]) return 12'hF80;
      for (int i = 1; i < m_len; i++) if (idx == m_loc[i]) return 12'hFF0;
    end
    if (m_fv && idx == m_food) return 12'hFFF;
    return mbg();
  endfunction

  function automatic bit probe(input int h, input int v);
    int dh, dv, mh, mv;
    dh = h - HO;
    dv = v - VO;
    if (fs_v >= 0 && v == fs_v && h >= fs_h - 2 && h <= fs_h + 2) return 1;
    if (dv < 0) return 0;
    mv = dv % CELL;
    if (!(mv == 0 || mv == 5 || mv == CELL - 1)) return 0;
    if (dh < 0) return 1;
    mh = dh % CELL;
    return (mh == 0 || mh == 5 || mh == CELL - 1);
  endfunction

  // One clock: drive at negedge, push expectation, compare after the edge
  task automatic step(input bit pe, input bit fs, input int h, input int v, input bit br, input bit chk);
    sb_t e;
    @(negedge Clk);
    Pix_En = pe; Frame_Start = fs; hCount = 10'(h); vCount = 10'(v); Bright = br;
    if (fs) model_snap();
    if (pe) begin
      e.chk = chk; e.exp = mpix(h, v, br); e.h = h; e.v = v;
      sbq.push_back(e);
    end
    @(posedge Clk);
    #1;
    if (pe) begin
      if (sbq.size() >= 2) begin
        e = sbq.pop_front();
        last_exp = e.exp;
        if (e.chk) check($sformatf("rgb h=%0d v=%0d", e.h, e.v), 32'(rgb), 32'(e.exp));
      end
    end else if (chk) begin
      check("rgb_hold", 32'(rgb), 32'(last_exp));
    end
    Frame_Start = 1'b0;
  endtask

  task automatic scan(input int vl, input int hp, input bit do_fs);
    bit br, fs;
    if (do_fs) step(0, 1, 0, 0, 0, 1);
    for (int v = VO - 1; v < VO + vl; v++) begin
      for (int h = HO - 1; h < HO + hp; h++) begin
        br = (h >= HO && v >= VO);
        fs = (h == fs_h && v == fs_v);
        step(1, fs, h, v, br, probe(h, v));
        if (gaps) step(0, 0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1, 1);
      end
    end
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
  endtask

  bg_vec_t tbl[7];

  initial begin
    tbl[0] = '{0, 0, 0, 0, 12'h000};
    tbl[1] = '{1, 1, 1, 1, 12'h000};
    tbl[2] = '{0, 1, 0, 0, 12'h0F0};
    tbl[3] = '{0, 0, 1, 0, 12'hF00};
    tbl[4] = '{0, 1, 1, 1, 12'hF00};
    tbl[5] = '{1, 0, 1, 0, 12'h000};
    tbl[6] = '{0, 0, 0, 1, 12'h000};

    Reset = 1'b1; Pix_En = 0; Bright = 0; Frame_Start = 0;
    Qi = 0; Qw = 0; Ql = 0; Qc = 0; hCount = '0; vCount = '0;
    Food = '0; Locations_Flat = '0; Length = '0;
    p_len = 0; m_len = 0; m_food = 0; m_fc = 0; m_fv = 0; last_exp = '0;
    for (int i = 0; i < ML; i++) begin p_loc[i] = 0; m_loc[i] = 0; end

    repeat (3) @(posedge Clk);
    #1;
    check("reset_rgb", 32'(rgb), 32'h0);
    check("reset_bg", 32'(background), 32'h0);
    check("reset_fc", 32'(Frame_Count), 32'h0);
    @(negedge Clk) Reset = 1'b0;

    // Background priority table
    for (int k = 0; k < 7; k++) begin
      @(negedge Clk);
      Qi = tbl[k].qi; Qw = tbl[k].qw; Ql = tbl[k].ql; Qc = tbl[k].qc;
      @(posedge Clk);
      #1;
      check($sformatf("bg_vec%0d", k), 32'(background), 32'(tbl[k].bg));
    end
    @(negedge Clk); Qi = 0; Qw = 0; Ql = 0; Qc = 0;

    // Nothing drawn before the first snapshot
    set_snake(3, 1);
    scan(6, 120, 0);

    // Basic snake at 17,18,19
    set_snake(3, 17);
    scan(36, 120, 1);

    // Mid-frame input change is invisible until the next snapshot
    set_snake(3, 33);
    scan(36, 120, 0);
    scan(66, 120, 1);

    // Food latched with Qc, held when Qc drops
    set_snake(3, 17);
    Qc = 1; Food = 8'h22;
    scan(66, 90, 1);
    Qc = 0; Food = 8'h05;
    scan(66, 90, 1);

    // Snapshot in the same cycle as a pixel strobe, mid-line
    set_snake(3, 1);
    fs_h = HO + 45; fs_v = VO + 5;
    scan(6, 150, 0);
    fs_h = -1; fs_v = -1;

    // Lose blink over 16 frames with food under a body segment
    Ql = 1; Qw = 1; Qc = 1; Food = 8'h02;
    for (int f = 0; f < 16; f++) scan(6, 150, 1);
    check("bg_lose_over_win", 32'(background), 32'hF00);
    check("frame_count", 32'(Frame_Count), 32'(m_fc));

    // Length clamping and out-of-length segments
    Ql = 0; Qc = 0;
    set_snake(20, 0);
    scan(6, 480, 1);
    set_snake(15, 0);
    scan(6, 480, 1);
    set_snake(0, 0);
    scan(6, 480, 1);

    // Init state hides snake and food
    set_snake(3, 1);
    Qi = 1;
    scan(6, 150, 1);
    Qi = 0;
    scan(6, 150, 1);

    // Asynchronous reset in the middle of a line
    for (int h = HO - 1; h <= HO + 40; h++) step(1, 0, h, VO + 5, h >= HO, 1);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("midrst_rgb", 32'(rgb), 32'h0);
    check("midrst_bg", 32'(background), 32'h0);
    check("midrst_fc", 32'(Frame_Count), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    sbq.delete();
    m_len = 0; m_fv = 0; m_fc = 0; m_food = 0; last_exp = '0;
    for (int i = 0; i < ML; i++) m_loc[i] = 0;
    scan(6, 150, 0);
    scan(6, 150, 1);

    // Latency counts strobes: idle cycles with junk coordinates in between
    gaps = 1;
    Qw = 0;
    scan(6, 150, 1);
    gaps = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
